// File: rtl/video_raster_sequencer_if.sv
// Bundle between the raster sequencer and its surroundings: CPU list port,
// video timing inputs, register-write strobe and status.
interface video_raster_sequencer_if #(
  parameter int ADDR_BITS = 6
);
  logic                 enable;
  logic [ADDR_BITS-1:0] list_addr;
  logic [31:0]          list_wrdata;
  logic                 list_wren;
  logic [31:0]          list_rddata;
  logic [8:0]           vline;
  logic                 vnewframe;
  logic                 vnext;
  logic [3:0]           regwr_addr;
  logic [15:0]          regwr_data;
  logic                 regwr_en;
  logic                 busy;
  logic [ADDR_BITS-1:0] pc;
  logic                 overrun;
  logic                 overrun_clr;

  modport master (
    output enable, list_addr, list_wrdata, list_wren, vline, vnewframe, vnext, overrun_clr,
    input  list_rddata, regwr_addr, regwr_data, regwr_en, busy, pc, overrun
  );

  modport slave (
    input  enable, list_addr, list_wrdata, list_wren, vline, vnewframe, vnext, overrun_clr,
    output list_rddata, regwr_addr, regwr_data, regwr_en, busy, pc, overrun
  );
endinterface

// File: rtl/video_raster_sequencer.sv
// Raster-synchronised "copper": walks a CPU-written command list once per
// frame, waiting on scanlines and issuing one-cycle video register writes.
module video_raster_sequencer #(
  parameter int ADDR_BITS = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  video_raster_sequencer_if.slave seq_io
);

  typedef enum logic [2:0] {
    IDLE, FETCH, EXEC, WAIT_LINE, WAIT_NEXT, DONE
  } state_e;

  localparam logic [1:0] OP_WAIT  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_NEXT  = 2'b10;
  localparam logic [1:0] OP_END   = 2'b11;

  logic [31:0]          mem_q [2**ADDR_BITS];
  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] pc_q, pc_d;
  logic [1:0]           op_q, op_d;
  logic [3:0]           reg_q, reg_d;
  logic [15:0]          data_q, data_d;
  logic                 last_q, last_d;
  logic                 wr_en_q, wr_en_d;
  logic [3:0]           wr_addr_q, wr_addr_d;
  logic [15:0]          wr_data_q, wr_data_d;
  logic                 overrun_q, overrun_d;
  logic                 line_hit;
  state_e               cont_state;

  // Distributed RAM: write lands at the edge, so a same-cycle fetch sees old data.
  always_ff @(posedge clk) begin
    if (seq_io.list_wren) begin
      mem_q[seq_io.list_addr] <= seq_io.list_wrdata;
    end
  end

  assign line_hit   = (seq_io.vline >= data_q[8:0]);
  assign cont_state = last_q ? DONE : FETCH;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    op_d      = op_q;
    reg_d     = reg_q;
    data_d    = data_q;
    last_d    = last_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    // Clear first so that a same-cycle overrun set below wins.
    overrun_d = overrun_q & ~seq_io.overrun_clr;

    if (!seq_io.enable) begin
      state_d = IDLE;
    end else if (seq_io.vnewframe) begin
      state_d = FETCH;
      pc_d    = '0;
      if (state_q != IDLE && state_q != DONE) begin
        overrun_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        IDLE: state_d = IDLE;
        FETCH: begin
          op_d    = mem_q[pc_q][31:30];
          reg_d   = mem_q[pc_q][19:16];
          data_d  = mem_q[pc_q][15:0];
          last_d  = &pc_q;
          pc_d    = pc_q + ADDR_BITS'(1);
          state_d = EXEC;
        end
        EXEC: begin
          unique case (op_q)
            OP_WAIT:  state_d = line_hit ? cont_state : WAIT_LINE;
            OP_WRITE: begin
              wr_en_d   = 1'b1;
              wr_addr_d = reg_q;
              wr_data_d = data_q;
              state_d   = cont_state;
            end
            OP_NEXT:  state_d = WAIT_NEXT;
            OP_END:   state_d = DONE;
            default:  state_d = DONE;
          endcase
        end
        WAIT_LINE: if (line_hit) state_d = cont_state;
        WAIT_NEXT: if (seq_io.vnext) state_d = cont_state;
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      op_q      <= OP_WAIT;
      reg_q     <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      op_q      <= op_d;
      reg_q     <= reg_d;
      data_q    <= data_d;
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      overrun_q <= overrun_d;
    end
  end

  assign seq_io.list_rddata = mem_q[seq_io.list_addr];
  assign seq_io.regwr_en    = wr_en_q;
  assign seq_io.regwr_addr  = wr_addr_q;
  assign seq_io.regwr_data  = wr_data_q;
  assign seq_io.pc          = pc_q;
  assign seq_io.overrun     = overrun_q;
  assign seq_io.busy        = (state_q == FETCH) || (state_q == EXEC) ||
                              (state_q == WAIT_LINE) || (state_q == WAIT_NEXT);

endmodule

// File: tb/tb_video_raster_sequencer.sv
// Scoreboard bench for the raster sequencer: expected register writes are
// queued by the stimulus thread and popped by a negedge monitor.
module tb_video_raster_sequencer;
  localparam int ADDR_BITS = 6;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nCompared = 0;
  int   nMismatched = 0;
  int   cycleCount = 0;
  int   pe, hitEdge, lat0, lat1;
  wr_t  expQ[$];
  wr_t  expWr;
  int   wrCycles[$];

  video_raster_sequencer_if #(.ADDR_BITS(ADDR_BITS)) bus();

  video_raster_sequencer #(.ADDR_BITS(ADDR_BITS)) dut (
    .clk    (clk),
    .reset  (reset),
    .seq_io (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Every strobe seen must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (!reset && bus.regwr_en === 1'b1) begin
      wrCycles.push_back(cycleCount);
      nCompared++;
      if (expQ.size() == 0) begin
        nMismatched++;
        $display("[TB] FAIL unexpected_write: got r%0d=0x%04h, required no write",
                 bus.regwr_addr, bus.regwr_data);
      end else begin
        expWr = expQ.pop_front();
        if ({bus.regwr_addr, bus.regwr_data} !== expWr) begin
          nMismatched++;
          $display("[TB] FAIL write_value: got r%0d=0x%04h, required r%0d=0x%04h",
                   bus.regwr_addr, bus.regwr_data, expWr.addr, expWr.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic loadEntry(input int idx, input logic [31:0] word);
    bus.list_addr   = ADDR_BITS'(idx);
    bus.list_wrdata = word;
    bus.list_wren   = 1'b1;
    tick();
    bus.list_wren   = 1'b0;
  endtask

  // Pulses vnewframe for one cycle; returns the count of the edge that samples it.
  task automatic applyStimulus(output int sampleEdge);
    bus.vnewframe = 1'b1;
    sampleEdge    = cycleCount + 1;
    tick();
    bus.vnewframe = 1'b0;
  endtask

  task automatic checkWrites(input string name, input int n);
    checkOutput({name, "_write_count"}, wrCycles.size(), n);
    checkOutput({name, "_queue_drained"}, expQ.size(), 0);
  endtask

  function automatic logic [31:0] cmdWrite(input int r, input int d);
    return {2'b01, 10'd0, 4'(r), 16'(d)};
  endfunction

  function automatic logic [31:0] cmdWait(input int line);
    return {2'b00, 21'd0, 9'(line)};
  endfunction

  function automatic int latency(input int idx, input int ref_edge);
    return (wrCycles.size() > idx) ? wrCycles[idx] - ref_edge : -1;
  endfunction

  localparam logic [31:0] CMD_NEXT = 32'h8000_0000;
  localparam logic [31:0] CMD_END  = 32'hC000_0000;

  initial begin
    bus.enable      = 1'b0;
    bus.list_addr   = '0;
    bus.list_wrdata = '0;
    bus.list_wren   = 1'b0;
    bus.vline       = '0;
    bus.vnewframe   = 1'b0;
    bus.vnext       = 1'b0;
    bus.overrun_clr = 1'b0;

    #2;
    checkOutput("reset_regwr_en", bus.regwr_en, 0);
    checkOutput("reset_regwr_addr", bus.regwr_addr, 0);
    checkOutput("reset_regwr_data", bus.regwr_data, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_pc", bus.pc, 0);
    checkOutput("reset_overrun", bus.overrun, 0);
    tick();
    tick();
    reset = 1'b0;
    bus.enable = 1'b1;

    // Two back-to-back writes then END.
    loadEntry(0, cmdWrite(3, 16'h0055));
    loadEntry(1, cmdWrite(4, 16'h1234));
    loadEntry(2, CMD_END);
    bus.list_addr = 6'd1;
    #1;
    checkOutput("t1_list_readback", bus.list_rddata, cmdWrite(4, 16'h1234));
    expQ.push_back('{4'd3, 16'h0055});
    expQ.push_back('{4'd4, 16'h1234});
    wrCycles.delete();
    applyStimulus(pe);
    repeat (12) tick();
    checkWrites("t1", 2);
    checkOutput("t1_first_latency", latency(0, pe), 2);
    checkOutput("t1_second_latency", latency(1, pe), 4);
    checkOutput("t1_busy_done", bus.busy, 0);
    checkOutput("t1_overrun", bus.overrun, 0);
    checkOutput("t1_pc", bus.pc, 3);

    // WAIT for line 100 while vline steps up.
    bus.vline = 9'd98;
    loadEntry(0, cmdWait(100));
    loadEntry(1, cmdWrite(1, 16'h00A0));
    loadEntry(2, CMD_END);
    expQ.push_back('{4'd1, 16'h00A0});
    wrCycles.delete();
    applyStimulus(pe);
    repeat (5) tick();
    bus.vline = 9'd99;
    repeat (5) tick();
    checkOutput("t2_no_early_write", wrCycles.size(), 0);
    checkOutput("t2_busy_waiting", bus.busy, 1);
    bus.vline = 9'd100;
    hitEdge = cycleCount + 1;
    repeat (8) tick();
    checkWrites("t2", 1);
    lat0 = latency(0, hitEdge);
    checkOutput("t2_latency_within_3", (lat0 >= 0 && lat0 <= 3), 1);

    // NEXTLINE pacing with vnext every 10 cycles.
    loadEntry(0, CMD_NEXT);
    loadEntry(1, cmdWrite(2, 7));
    loadEntry(2, CMD_NEXT);
    loadEntry(3, cmdWrite(2, 8));
    loadEntry(4, CMD_END);
    expQ.push_back('{4'd2, 16'd7});
    expQ.push_back('{4'd2, 16'd8});
    wrCycles.delete();
    applyStimulus(pe);
    for (int i = 0; i < 50; i++) begin
      bus.vnext = (i % 10 == 5);
      tick();
    end
    bus.vnext = 1'b0;
    checkWrites("t3", 2);
    lat0 = latency(0, pe);
    lat1 = latency(1, pe);
    checkOutput("t3_write_spacing", lat1 - lat0, 10);
    checkOutput("t3_busy_done", bus.busy, 0);

    // Unreachable WAIT target stalls the list; restart flags overrun.
    bus.vline = 9'd200;
    loadEntry(0, cmdWait(300));
    loadEntry(1, CMD_END);
    wrCycles.delete();
    applyStimulus(pe);
    repeat (6) tick();
    checkOutput("t4_overrun_first_frame", bus.overrun, 0);
    checkOutput("t4_pc_stalled", bus.pc, 1);
    checkOutput("t4_busy_stalled", bus.busy, 1);
    applyStimulus(pe);
    checkOutput("t4_overrun_set", bus.overrun, 1);
    repeat (3) tick();
    checkOutput("t4_pc_after_restart", bus.pc, 1);
    checkOutput("t4_overrun_sticky", bus.overrun, 1);
    checkOutput("t4_no_writes", wrCycles.size(), 0);
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    checkOutput("t4_overrun_cleared", bus.overrun, 0);
    bus.overrun_clr = 1'b1;
    bus.vnewframe   = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    bus.vnewframe   = 1'b0;
    checkOutput("t4_set_beats_clear", bus.overrun, 1);
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    checkOutput("t4_overrun_cleared_again", bus.overrun, 0);
    bus.enable = 1'b0;
    tick();
    bus.enable = 1'b1;
    checkOutput("t4_idle_on_disable", bus.busy, 0);

    // Full 64-entry list of writes, wrapping pc and ending in DONE.
    for (int i = 0; i < 64; i++) loadEntry(i, cmdWrite(i % 16, i));
    bus.list_addr = 6'd63;
    #1;
    checkOutput("t5_list_readback", bus.list_rddata, cmdWrite(15, 63));
    for (int i = 0; i < 64; i++) expQ.push_back('{4'(i % 16), 16'(i)});
    wrCycles.delete();
    applyStimulus(pe);
    repeat (140) tick();
    checkWrites("t5_full", 64);
    checkOutput("t5_busy_done", bus.busy, 0);
    checkOutput("t5_pc_wrapped", bus.pc, 0);
    checkOutput("t5_overrun", bus.overrun, 0);

    // Drop enable while entry 10 sits in EXEC: its write must not appear.
    for (int i = 0; i < 10; i++) expQ.push_back('{4'(i % 16), 16'(i)});
    wrCycles.delete();
    applyStimulus(pe);
    repeat (21) tick();
    bus.enable = 1'b0;
    tick();
    checkOutput("t5_idle_after_disable", bus.busy, 0);
    repeat (10) tick();
    checkWrites("t5_abort", 10);
    applyStimulus(pe);
    repeat (4) tick();
    checkOutput("t5_frame_ignored_disabled", bus.busy, 0);

    // Asynchronous reset in the strobe cycle, then a clean restart.
    bus.enable = 1'b1;
    wrCycles.delete();
    applyStimulus(pe);
    tick();
    tick();
    checkOutput("t6_strobe_before_reset", bus.regwr_en, 1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("t6_regwr_en_async", bus.regwr_en, 0);
    checkOutput("t6_pc_async", bus.pc, 0);
    checkOutput("t6_busy_async", bus.busy, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 64; i++) expQ.push_back('{4'(i % 16), 16'(i)});
    wrCycles.delete();
    applyStimulus(pe);
    repeat (140) tick();
    checkWrites("t6_restart", 64);
    checkOutput("t6_first_latency", latency(0, pe), 2);
    checkOutput("t6_busy_done", bus.busy, 0);
    checkOutput("t6_overrun", bus.overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
